// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame_arbiter
// Purpose  : Shares one UART transmitter between two byte requesters. Each
//            accepted request becomes an atomic two-byte frame: a
//            requester-specific header, then the requester's data byte.
//            Selection is round-robin. Frames never interleave.
// Ports    : clk_50mhz, reset      - system clock, synchronous active-high reset
//            req0_valid/data/ready - requester 0 (sample echo path)
//            req1_valid/data/ready - requester 1 (event reporter)
//            tx_active, tx_done    - status from uart_tx
//            tx_dv, tx_byte        - one-cycle load strobe and byte to uart_tx
//            grant                 - one-hot owner of the current frame, 0 when idle
//            busy                  - FSM is not in IDLE
//            frames_sent           - completed-frame counter (wraps)
//            tx_error              - one-cycle pulse on watchdog abort
// Options  : TX_ARB_TIMEOUT_EN - when defined, a per-byte watchdog aborts a
//            frame whose tx_done never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame_arbiter #(
  parameter logic [7:0] HDR0            = 8'hAA,
  parameter logic [7:0] HDR1            = 8'h55,
  parameter int         TX_TIMEOUT_CLKS = 5000
) (
  input  logic        clk_50mhz,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        tx_active,
  input  logic        tx_done,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        tx_error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_HDR = 3'd1,
    WAIT_HDR = 3'd2,
    SEND_DAT = 3'd3,
    WAIT_DAT = 3'd4
  } state_t;

  state_t     state;
  logic       last;       // index of the requester served most recently
  logic [7:0] data_q;     // data byte latched at accept
  logic       sel;        // requester chosen in IDLE
  logic       sel_valid;  // some requester is offering a byte

  // Round-robin pick: on a tie the requester that was not served last wins.
  always_comb begin
    sel       = 1'b0;
    sel_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      sel = ~last;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign req0_ready = (state == IDLE) && sel_valid && !sel;
  assign req1_ready = (state == IDLE) && sel_valid &&  sel;
  assign busy       = (state != IDLE);

`ifdef TX_ARB_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TX_TIMEOUT_CLKS - 1);
  logic [12:0] wd_cnt;
`else
  // Without the watchdog a lost tx_done stalls the frame until reset.
  assign tx_error = 1'b0;
`endif

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      state       <= IDLE;
      tx_dv       <= 1'b0;
      tx_byte     <= 8'h00;
      grant       <= 2'b00;
      frames_sent <= 16'h0000;
      last        <= 1'b1;     // so requester 0 wins the first tie
      data_q      <= 8'h00;
`ifdef TX_ARB_TIMEOUT_EN
      tx_error    <= 1'b0;
      wd_cnt      <= 13'd0;
`endif
    end else begin
      tx_dv <= 1'b0;           // strobe is a single-cycle pulse
`ifdef TX_ARB_TIMEOUT_EN
      tx_error <= 1'b0;
      wd_cnt   <= 13'd0;       // only counts while parked in a WAIT state
`endif
      case (state)
        IDLE: begin
          if (sel_valid) begin
            data_q <= sel ? req1_data : req0_data;
            grant  <= sel ? 2'b10 : 2'b01;
            state  <= SEND_HDR;
          end
        end
        SEND_HDR: begin
          // A byte still shifting out (possibly from before a reset) must finish first.
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= grant[1] ? HDR1 : HDR0;
            state   <= WAIT_HDR;
          end
        end
        WAIT_HDR: begin
          if (tx_done) begin
            state <= SEND_DAT;
          end
        end
        SEND_DAT: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= data_q;
            state   <= WAIT_DAT;
          end
        end
        WAIT_DAT: begin
          if (tx_done) begin
            state       <= IDLE;
            last        <= grant[1];
            frames_sent <= frames_sent + 16'd1;
            grant       <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
`ifdef TX_ARB_TIMEOUT_EN
      // Abort overrides the case above only when tx_done is absent, so it
      // never competes with a normal WAIT_* exit.
      if ((state == WAIT_HDR || state == WAIT_DAT) && !tx_done) begin
        if (wd_cnt == WD_LAST) begin
          state    <= IDLE;
          tx_error <= 1'b1;
          grant    <= 2'b00;
          last     <= grant[1];
        end else begin
          wd_cnt <= wd_cnt + 13'd1;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_frame_arbiter
// Purpose  : Self-checking bench for uart_tx_frame_arbiter. A bench-side UART
//            model answers each tx_dv; a frame-level model (expected byte
//            queue, owner, frame count) is compared against the DUT on every
//            falling edge. Directed tests add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_arbiter;

  localparam logic [7:0] H0        = 8'hAA;
  localparam logic [7:0] H1        = 8'h55;
  localparam int         BYTE_CLKS = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        req0_ready, req1_ready;
  logic        uart_busy = 1'b0, force_active = 1'b0, drop_done = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_active;
  logic        tx_dv, busy, tx_error;
  logic [7:0]  tx_byte;
  logic [1:0]  grant;
  logic [15:0] frames_sent;

  assign tx_active = uart_busy | force_active;

  always #10 clk = ~clk;

  uart_tx_frame_arbiter dut (
    .clk_50mhz  (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .tx_dv      (tx_dv),
    .tx_byte    (tx_byte),
    .grant      (grant),
    .busy       (busy),
    .frames_sent(frames_sent),
    .tx_error   (tx_error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- frame-level model + UART model ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic        m_in_frame = 1'b0;
  logic        m_owner    = 1'b0;
  logic        m_last     = 1'b1;
  logic [15:0] m_frames   = 16'h0;
  int          m_strobes  = 0;
  logic        m_hold     = 1'b0;
  logic        prev_dv    = 1'b0;
  logic        prev_active = 1'b0;
  int          ucnt       = 0;

  always @(negedge clk) begin
    logic exp_r0, exp_r1;
    // Compare DUT state (after the last rising edge) with the model.
    exp_r0 = !m_in_frame && req0_valid && (!req1_valid || m_last);
    exp_r1 = !m_in_frame && req1_valid && (!req0_valid || !m_last);
    if (!m_hold) begin
      check("busy", busy, m_in_frame);
      check("grant", grant, m_in_frame ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      check("req0_ready", req0_ready, exp_r0);
      check("req1_ready", req1_ready, exp_r1);
      check("frames_sent", frames_sent, m_frames);
`ifndef TX_ARB_TIMEOUT_EN
      check("tx_error", tx_error, 0);
`endif
    end
    if (tx_dv) begin
      obs_q.push_back(tx_byte);
      check("dv_back_to_back", prev_dv, 0);
      check("dv_while_active", prev_active, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: got byte 0x%0h, expected no strobe at %0t", tx_byte, $time);
      end else begin
        check("tx_byte", tx_byte, exp_q.pop_front());
        m_strobes++;
      end
    end
    // UART model: busy for BYTE_CLKS cycles after each load, then tx_done.
    if (tx_dv) begin
      uart_busy = 1'b1;
      ucnt      = BYTE_CLKS;
      tx_done   = 1'b0;
    end else if (uart_busy) begin
      ucnt--;
      if (ucnt == 0) begin
        uart_busy = 1'b0;
        tx_done   = !drop_done;
      end else begin
        tx_done = 1'b0;
      end
    end else begin
      tx_done = 1'b0;
    end
    // Arbitration model: what the DUT does at the coming rising edge.
    if (reset) begin
      m_in_frame = 1'b0;
      m_last     = 1'b1;
      m_frames   = 16'h0;
      m_strobes  = 0;
      exp_q.delete();
    end else if (!m_in_frame) begin
      if (req0_valid || req1_valid) begin
        m_owner    = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_in_frame = 1'b1;
        m_strobes  = 0;
        exp_q.push_back(m_owner ? H1 : H0);
        exp_q.push_back(m_owner ? req1_data : req0_data);
      end
    end else if (tx_done && m_strobes == 2) begin
      m_in_frame = 1'b0;
      m_last     = m_owner;
      m_frames   = m_frames + 16'd1;
    end
    prev_dv     = tx_dv;
    prev_active = uart_busy | force_active;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait (at falling edges) until the given ready is high; then step past the accept edge.
  task automatic accept(input int which, input string name);
    int cyc = 0;
    @(negedge clk);
    while (!(which == 0 ? req0_ready : req1_ready) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got no ready, expected ready within 2000 cycles", name);
    end
    step();
  endtask

  task automatic wait_done(input int nbytes, input string name);
    int cyc = 0;
    @(negedge clk);
    while (!(obs_q.size() >= nbytes && !busy && !uart_busy) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_done_timeout: got %0d bytes, expected %0d", name, obs_q.size(), nbytes);
    end
    step();
  endtask

  task automatic check_obs(input string name, input int n, input logic [63:0] e);
    check({name, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check({name, "_byte"}, obs_q[i], e[63-8*i -: 8]);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cnt;
    int cyc;
    int nbusy0;
    int nerr;

    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_tx_error", tx_error, 0);
    step();

    // T1: lone requester 0
    obs_q.delete();
    req0_valid = 1'b1;
    req0_data  = 8'hFA;
    @(negedge clk);
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_grant", grant, 2'b01);
    wait_done(2, "t1");
    check_obs("t1", 2, 64'hAAFA_0000_0000_0000);
    check("t1_frames", frames_sent, 1);

    // T2: simultaneous requests after reset, requester 0 first
    do_reset();
    obs_q.delete();
    req0_valid = 1'b1;
    req0_data  = 8'h32;
    req1_valid = 1'b1;
    req1_data  = 8'h01;
    accept(0, "t2_r0");
    req0_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!req1_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("t2_r1_ready_after_frame", frames_sent, 1);
    step();
    req1_valid = 1'b0;
    wait_done(4, "t2");
    check_obs("t2", 4, 64'hAA32_5501_0000_0000);
    check("t2_frames", frames_sent, 2);

    // T3: both held for four frames; owners alternate 0,1,0,1
    do_reset();
    obs_q.delete();
    req0_valid = 1'b1;
    req0_data  = 8'h10;
    req1_valid = 1'b1;
    req1_data  = 8'h20;
    cnt = 0;
    cyc = 0;
    while (cnt < 4 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) cnt++;
    end
    check("t3_accepts", cnt, 4);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done(8, "t3");
    check_obs("t3", 8, 64'hAA10_5520_AA10_5520);
    check("t3_frames", frames_sent, 4);

    // T4: tx_active held high for 100 clocks after accept
    do_reset();
    obs_q.delete();
    req0_valid = 1'b1;
    req0_data  = 8'h5A;
    accept(0, "t4");
    force_active = 1'b1;
    req0_valid   = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_dv) cnt++;
    end
    check("t4_strobes_while_active", cnt, 0);
    @(posedge clk);
    #1;
    force_active = 1'b0;
    @(negedge clk);
    check("t4_no_dv_before_edge", tx_dv, 0);
    @(negedge clk);
    check("t4_dv_after_release", tx_dv, 1);
    wait_done(2, "t4");
    check_obs("t4", 2, 64'hAA5A_0000_0000_0000);

    // T5: reset during WAIT_DAT, then a lone requester 1
    do_reset();
    obs_q.delete();
    req0_valid = 1'b1;
    req0_data  = 8'h3C;
    accept(0, "t5");
    req0_valid = 1'b0;
    cyc = 0;
    while (obs_q.size() < 2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_busy_before_reset", busy, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_grant", grant, 0);
    check("t5_frames", frames_sent, 0);
    step();
    obs_q.delete();
    req1_valid = 1'b1;
    req1_data  = 8'h07;
    accept(1, "t5");
    req1_valid = 1'b0;
    wait_done(2, "t5b");
    check_obs("t5", 2, 64'h5507_0000_0000_0000);
    check("t5_frames_after", frames_sent, 1);

    // T6: tx_done suppressed
    do_reset();
    obs_q.delete();
    drop_done  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    accept(0, "t6");
    req0_valid = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    cyc = 0;
    while (obs_q.size() < 1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    m_hold = 1'b1;
    cyc = 0;
    while (!tx_error && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_error_delay", cyc, 5000);
    @(negedge clk);
    check("t6_error_pulse_width", tx_error, 0);
    check("t6_busy", busy, 0);
    check("t6_frames", frames_sent, 0);
    step();
    drop_done = 1'b0;
    do_reset();
    m_hold = 1'b0;
`else
    nbusy0 = 0;
    nerr   = 0;
    repeat (20000) begin
      @(negedge clk);
      if (!busy) nbusy0++;
      if (tx_error) nerr++;
    end
    check("t6_busy_low_cycles", nbusy0, 0);
    check("t6_error_cycles", nerr, 0);
    step();
    drop_done = 1'b0;
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 3 ms");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_arbiter.md
# uart_tx_frame_arbiter

Frame-level arbiter that shares the single UART transmitter of the Colorlight i9 echo design between two requesters: the filtered-sample echo path (requester 0) and the button/status event reporter (requester 1). Each accepted request becomes an atomic two-byte frame: a requester-specific header, then one data byte. Frames from different requesters never interleave. The block sits between the processing FSM and `uart_tx`, and drives `tx_dv`/`tx_byte` in place of the FSM.

## Interface
- `HDR0`, default 8'hAA: header byte for requester 0 (sample frames).
- `HDR1`, default 8'h55: header byte for requester 1 (event frames).
- `TX_TIMEOUT_CLKS`, default 5000: watchdog limit in clocks per byte. It must exceed 10 × CLKS_PER_BIT (434).

- `clk_50mhz`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 data byte.
- `req0_ready`  out  1  requester 0 byte accepted on valid&ready.
- `req1_valid`, `req1_data`, `req1_ready`: same as above, for requester 1.
- `tx_active`  in  1  from `uart_tx`: frame in progress.
- `tx_done`  in  1  from `uart_tx`: one-cycle pulse at end of stop bit.
- `tx_dv`  out  1  one-cycle load strobe to `uart_tx`.
- `tx_byte`  out  8  byte to transmit; valid when `tx_dv`=1.
- `grant`  out  2  one-hot owner of the current frame; 2'b00 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `frames_sent`  out  16  count of completed frames; wraps at 16'hFFFF→0.
- `tx_error`  out  1  one-cycle pulse on watchdog abort.

## Operation
- **FSM states:** IDLE, SEND_HDR, WAIT_HDR, SEND_DAT, WAIT_DAT.
- **IDLE:**
  - Selection is round-robin. `last` holds the last requester served.
  - If both requesters are valid, select the one not equal to `last`. If only one is valid, select it.
  - `reqN_ready` is combinational: `(state==IDLE) && selected==N`. The non-selected ready stays 0.
  - On `valid&&ready`: latch data and `grant`, then go to SEND_HDR.
- **SEND_HDR:**
  - If `tx_active`=0: register `tx_dv`=1 and `tx_byte`=HDRn, then go to WAIT_HDR.
  - Otherwise stay in SEND_HDR.
- **WAIT_HDR:** on `tx_done`, go to SEND_DAT.
- **SEND_DAT:** same as SEND_HDR, but with the latched data byte. Go to WAIT_DAT.
- **WAIT_DAT:** on `tx_done`, go to IDLE. In the same edge: `last`←grant, `frames_sent`++, and `grant`←0.
- `tx_done` is ignored in IDLE and in the SEND states.
- Requester inputs are ignored outside IDLE. A requester may hold valid indefinitely; it is served next when its turn comes.
- **Reset (synchronous, any state):**
  - State←IDLE, `tx_dv`←0, `tx_byte`←0, `grant`←0, `frames_sent`←0, `tx_error`←0, watchdog←0.
  - `last`←1, so requester 0 wins the first tie.
  - A `uart_tx` frame already in flight is not aborted by this block. A following SEND waits for `tx_active` to fall.

## Timing
- **Accept edge E0:** state moves to SEND_HDR.
- **Header strobe:** earliest `tx_dv` is high for the cycle E1–E2, provided `tx_active`=0 at E1. `tx_dv` is never high for two consecutive cycles.
- **Data strobe:** `tx_done` seen at edge Ed moves the state to SEND_DAT. The data `tx_dv` is earliest high in the cycle after Ed+1.
- **Frame completion:** the `tx_done` of the data byte returns the FSM to IDLE. A new accept can occur in the next cycle.
- **Minimum arbitration gap:** 2 clocks between the last `tx_done` of one frame and the next header `tx_dv`.
- **Outputs:** all outputs are registered except `reqN_ready` and `busy`. `busy` is decoded from the state register.

## Configuration
- **`TX_ARB_TIMEOUT_EN` defined:**
  - A 13-bit watchdog counts in WAIT_HDR and WAIT_DAT. It clears on every state change.
  - On reaching TX_TIMEOUT_CLKS, the FSM goes to IDLE and pulses `tx_error` for one cycle.
  - `grant` clears, and `last` is updated to the aborted requester. `frames_sent` is not incremented.
- **`TX_ARB_TIMEOUT_EN` undefined:**
  - No watchdog logic; `tx_error` is tied to 0.
  - A missing `tx_done` stalls the FSM until reset.

## Test plan
1. Only `req0_valid` with 0xFA → one `req0_ready` pulse; `tx_byte` sequence 0xAA, 0xFA; `grant`=01 during the frame; `frames_sent`=1.
2. After reset, `req0` (0x32) and `req1` (0x01) asserted in the same cycle → bytes 0xAA, 0x32, 0x55, 0x01 with no interleave; `req1_ready`=0 until the first frame ends.
3. Both valid held continuously for 4 frames, data 0x10/0x20 → owners alternate 0, 1, 0, 1; `frames_sent`=4.
4. `tx_active` forced high for 100 clocks after accept → `tx_dv` stays 0 until the first cycle after `tx_active` falls, then exactly one strobe.
5. `reset` asserted during WAIT_DAT → next edge: `busy`=0, `grant`=0, `frames_sent`=0; a subsequent lone `req1` 0x07 yields 0x55, 0x07.
6. With `TX_ARB_TIMEOUT_EN`, `tx_done` suppressed → `tx_error` pulses 5000 clocks after the header `tx_dv`; FSM returns to IDLE and `frames_sent` is unchanged. Without the macro: `busy` stays 1 and `tx_error` stays 0 for 20000 clocks.
